// File: rtl/note_dropper.sv
// note_dropper: four-lane falling-note rhythm game core.
// Each lane keeps up to four notes that fall SPEED px per animation tick.
// A key press scores the first note whose bottom edge sits inside the hit
// window around HIT_Y; notes falling past the window are reported as misses.
// Pixel colour is registered on pixel strobes (one strobe of latency).
// Optional feature macro: NOTE_DROPPER_HITLINE_EN draws a white hit line at HIT_Y.

module note_dropper #(
  parameter int LANE_X0 = 160,
  parameter int LANE_W  = 80,
  parameter int NOTE_H  = 20,
  parameter int SPEED   = 2,
  parameter int HIT_Y   = 420,
  parameter int HIT_WIN = 16
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_pix_stb,
  input  logic       i_animate,
  input  logic       i_active,
  input  logic [9:0] i_x,
  input  logic [8:0] i_y,
  input  logic [3:0] i_spawn,
  input  logic [3:0] i_key,
  output logic [3:0] o_r,
  output logic [3:0] o_g,
  output logic [3:0] o_b,
  output logic [3:0] o_hit,
  output logic [3:0] o_miss,
  output logic [3:0] o_overflow
);

  localparam int NUM_LANES  = 4;
  localparam int NUM_SLOTS  = 4;
  localparam int LANE_INSET = 4;

  localparam logic [10:0] NOTE_H_W = 11'(NOTE_H);
  localparam logic [10:0] SPEED_W  = 11'(SPEED);
  localparam logic [10:0] WIN_LO   = 11'(HIT_Y - HIT_WIN);
  localparam logic [10:0] WIN_HI   = 11'(HIT_Y + HIT_WIN);

`ifdef NOTE_DROPPER_HITLINE_EN
  localparam logic [10:0] HIT_ROW     = 11'(HIT_Y);
  localparam logic [10:0] FIELD_LEFT  = 11'(LANE_X0);
  localparam logic [10:0] FIELD_RIGHT = 11'(LANE_X0 + NUM_LANES * LANE_W);
`endif

  logic [NUM_SLOTS-1:0] slotValid_q [NUM_LANES];
  logic [NUM_SLOTS-1:0] slotValid_d [NUM_LANES];
  logic [9:0]           slotY_q     [NUM_LANES][NUM_SLOTS];
  logic [9:0]           slotY_d     [NUM_LANES][NUM_SLOTS];

  logic [3:0] pending_q;
  logic [3:0] pending_d;
  logic [3:0] keyPrev_q;
  logic [3:0] keyEdge;
  logic       tick;

  logic [3:0] hit_d;
  logic [3:0] miss_d;
  logic [3:0] overflow_d;
  logic [3:0] pixR_d;
  logic [3:0] pixG_d;
  logic [3:0] pixB_d;

  assign tick    = i_animate & i_pix_stb;
  assign keyEdge = i_key & ~keyPrev_q;

  function automatic logic [11:0] laneColour(input int lane);
    case (lane)
      0:       laneColour = 12'h0F0;
      1:       laneColour = 12'hF00;
      2:       laneColour = 12'hFF0;
      default: laneColour = 12'h00F;
    endcase
  endfunction

  // Slot bookkeeping: hits use pre-move positions, survivors move on a tick, and a spawn takes a slot that was free at cycle start.
  always_comb begin : slotNext
    logic        hitTaken;
    logic        freeTaken;
    logic [10:0] bottom;
    logic [10:0] moved;
    slotValid_d = slotValid_q;
    slotY_d     = slotY_q;
    hit_d       = '0;
    miss_d      = '0;
    overflow_d  = '0;
    hitTaken    = 1'b0;
    freeTaken   = 1'b0;
    bottom      = '0;
    moved       = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      hitTaken  = 1'b0;
      freeTaken = 1'b0;
      for (int s = 0; s < NUM_SLOTS; s++) begin
        bottom = {1'b0, slotY_q[l][s]} + NOTE_H_W;
        moved  = {1'b0, slotY_q[l][s]} + SPEED_W;
        if (slotValid_q[l][s]) begin
          if (keyEdge[l] && !hitTaken && (bottom >= WIN_LO) && (bottom <= WIN_HI)) begin
            hitTaken          = 1'b1;
            slotValid_d[l][s] = 1'b0;
            hit_d[l]          = 1'b1;
          end else if (tick) begin
            if ((moved + NOTE_H_W) > WIN_HI) begin
              slotValid_d[l][s] = 1'b0;
              miss_d[l]         = 1'b1;
            end else begin
              slotY_d[l][s] = moved[9:0];
            end
          end
        end else if (tick && pending_q[l] && !freeTaken) begin
          freeTaken         = 1'b1;
          slotValid_d[l][s] = 1'b1;
          slotY_d[l][s]     = '0;
        end
      end
      if (tick && pending_q[l] && !freeTaken) begin
        overflow_d[l] = 1'b1;
      end
    end
    pending_d = (pending_q & ~{NUM_LANES{tick}}) | i_spawn;
  end

  // Pixel colour for the current beam position; lower lanes take priority, the hit line overrides notes.
  always_comb begin : pixelNext
    logic        drawn;
    logic        inLane;
    logic        onNote;
    logic [10:0] xW;
    logic [10:0] yW;
    logic [10:0] noteTop;
    xW      = {1'b0, i_x};
    yW      = {2'b0, i_y};
    drawn   = 1'b0;
    inLane  = 1'b0;
    onNote  = 1'b0;
    noteTop = '0;
    pixR_d  = '0;
    pixG_d  = '0;
    pixB_d  = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      inLane = (xW >= 11'(LANE_X0 + l * LANE_W + LANE_INSET)) &&
               (xW <  11'(LANE_X0 + (l + 1) * LANE_W - LANE_INSET));
      onNote = 1'b0;
      for (int s = 0; s < NUM_SLOTS; s++) begin
        noteTop = {1'b0, slotY_q[l][s]};
        if (slotValid_q[l][s] && (yW >= noteTop) && (yW < (noteTop + NOTE_H_W))) begin
          onNote = 1'b1;
        end
      end
      if (!drawn && inLane && onNote) begin
        drawn = 1'b1;
        {pixR_d, pixG_d, pixB_d} = laneColour(l);
      end
    end
`ifdef NOTE_DROPPER_HITLINE_EN
    if ((yW == HIT_ROW) && (xW >= FIELD_LEFT) && (xW < FIELD_RIGHT)) begin
      {pixR_d, pixG_d, pixB_d} = 12'hFFF;
    end
`endif
    if (!i_active) begin
      pixR_d = '0;
      pixG_d = '0;
      pixB_d = '0;
    end
  end

  // State and output registers; colour only advances on pixel strobes.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int l = 0; l < NUM_LANES; l++) begin
        slotValid_q[l] <= '0;
        for (int s = 0; s < NUM_SLOTS; s++) begin
          slotY_q[l][s] <= '0;
        end
      end
      pending_q  <= '0;
      keyPrev_q  <= '0;
      o_hit      <= '0;
      o_miss     <= '0;
      o_overflow <= '0;
      o_r        <= '0;
      o_g        <= '0;
      o_b        <= '0;
    end else begin
      slotValid_q <= slotValid_d;
      slotY_q     <= slotY_d;
      pending_q   <= pending_d;
      keyPrev_q   <= i_key;
      o_hit       <= hit_d;
      o_miss      <= miss_d;
      o_overflow  <= overflow_d;
      if (i_pix_stb) begin
        o_r <= pixR_d;
        o_g <= pixG_d;
        o_b <= pixB_d;
      end
    end
  end

endmodule

// File: tb/tb_note_dropper.sv
// tb_note_dropper: self-checking bench for note_dropper.
// Directed scenarios for falling, hit, miss, overflow, reset and pixel colour,
// followed by randomized traffic, all checked against a reference model that
// tracks each note by the tick on which it was loaded.

module tb_note_dropper;

  localparam int LANE_X0 = 160;
  localparam int LANE_W  = 80;
  localparam int NOTE_H  = 20;
  localparam int SPEED   = 2;
  localparam int HIT_Y   = 420;
  localparam int HIT_WIN = 16;

  logic       i_clk     = 1'b0;
  logic       i_rst     = 1'b0;
  logic       i_pix_stb = 1'b0;
  logic       i_animate = 1'b0;
  logic       i_active  = 1'b0;
  logic [9:0] i_x       = '0;
  logic [8:0] i_y       = '0;
  logic [3:0] i_spawn   = '0;
  logic [3:0] i_key     = '0;
  logic [3:0] o_r;
  logic [3:0] o_g;
  logic [3:0] o_b;
  logic [3:0] o_hit;
  logic [3:0] o_miss;
  logic [3:0] o_overflow;

  int checkCount = 0;
  int errorCount = 0;

  bit         mLive      [4][4];
  int         mSpawnTick [4][4];
  int         mTick    = 0;
  logic [3:0] mPending = '0;
  logic [3:0] mPrevKey = '0;
  logic [11:0] expCol  = '0;

  note_dropper #(
    .LANE_X0(LANE_X0),
    .LANE_W (LANE_W),
    .NOTE_H (NOTE_H),
    .SPEED  (SPEED),
    .HIT_Y  (HIT_Y),
    .HIT_WIN(HIT_WIN)
  ) dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_pix_stb (i_pix_stb),
    .i_animate (i_animate),
    .i_active  (i_active),
    .i_x       (i_x),
    .i_y       (i_y),
    .i_spawn   (i_spawn),
    .i_key     (i_key),
    .o_r       (o_r),
    .o_g       (o_g),
    .o_b       (o_b),
    .o_hit     (o_hit),
    .o_miss    (o_miss),
    .o_overflow(o_overflow)
  );

  always #5 i_clk = ~i_clk;

  // Hard stop in case the run stalls.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed %0h, expected %0h (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  function automatic int noteY(input int l, input int s);
    return SPEED * (mTick - mSpawnTick[l][s]);
  endfunction

  function automatic logic [11:0] laneColourRef(input int l);
    case (l)
      0:       return 12'h0F0;
      1:       return 12'hF00;
      2:       return 12'hFF0;
      default: return 12'h00F;
    endcase
  endfunction

  function automatic logic [11:0] modelColour(input int x, input int y, input logic act);
    logic [11:0] c;
    int ny;
    c = '0;
    if (!act) return '0;
    for (int l = 3; l >= 0; l--) begin
      if (x >= LANE_X0 + l * LANE_W + 4 && x < LANE_X0 + (l + 1) * LANE_W - 4) begin
        for (int s = 0; s < 4; s++) begin
          ny = noteY(l, s);
          if (mLive[l][s] && y >= ny && y < ny + NOTE_H) c = laneColourRef(l);
        end
      end
    end
`ifdef NOTE_DROPPER_HITLINE_EN
    if (y == HIT_Y && x >= LANE_X0 && x < LANE_X0 + 4 * LANE_W) c = 12'hFFF;
`endif
    return c;
  endfunction

  task automatic clearModel();
    for (int l = 0; l < 4; l++) begin
      for (int s = 0; s < 4; s++) begin
        mLive[l][s]      = 1'b0;
        mSpawnTick[l][s] = 0;
      end
    end
    mPending = '0;
    mPrevKey = '0;
    expCol   = '0;
  endtask

  // One clock cycle: drive inputs, predict this cycle's results, then compare after the edge.
  task automatic applyStimulus(input logic [3:0] spawn, input logic [3:0] key, input logic anim,
                               input logic stb, input logic act, input int x, input int y);
    logic [3:0] eHit;
    logic [3:0] eMiss;
    logic [3:0] eOvf;
    bit         liveAtStart [4][4];
    bit         tickNow;
    bit         loaded;
    int         bot;
    i_spawn   = spawn;
    i_key     = key;
    i_animate = anim;
    i_pix_stb = stb;
    i_active  = act;
    i_x       = 10'(x);
    i_y       = 9'(y);
    tickNow   = anim & stb;
    if (stb) expCol = modelColour(x, y, act);
    eHit = '0;
    eMiss = '0;
    eOvf = '0;
    liveAtStart = mLive;
    for (int l = 0; l < 4; l++) begin
      if (key[l] && !mPrevKey[l]) begin
        for (int s = 0; s < 4; s++) begin
          bot = noteY(l, s) + NOTE_H;
          if (mLive[l][s] && !eHit[l] && bot >= HIT_Y - HIT_WIN && bot <= HIT_Y + HIT_WIN) begin
            mLive[l][s] = 1'b0;
            eHit[l]     = 1'b1;
          end
        end
      end
      if (tickNow) begin
        for (int s = 0; s < 4; s++) begin
          if (liveAtStart[l][s] && mLive[l][s] && noteY(l, s) + SPEED + NOTE_H > HIT_Y + HIT_WIN) begin
            mLive[l][s] = 1'b0;
            eMiss[l]    = 1'b1;
          end
        end
        if (mPending[l]) begin
          loaded = 1'b0;
          for (int s = 0; s < 4; s++) begin
            if (!loaded && !liveAtStart[l][s]) begin
              loaded           = 1'b1;
              mLive[l][s]      = 1'b1;
              mSpawnTick[l][s] = mTick + 1;
            end
          end
          if (!loaded) eOvf[l] = 1'b1;
        end
      end
    end
    if (tickNow) mTick++;
    mPending = (mPending & ~{4{tickNow}}) | spawn;
    mPrevKey = key;
    @(posedge i_clk);
    #1;
    checkOutput("hit", o_hit, eHit);
    checkOutput("miss", o_miss, eMiss);
    checkOutput("overflow", o_overflow, eOvf);
    checkOutput("colour", {o_r, o_g, o_b}, expCol);
  endtask

  // One frame: a drawing cycle with a random pixel, then the tick cycle.
  task automatic runFrame(input logic [3:0] spawn, input logic [3:0] key);
    applyStimulus(spawn, key, 1'b0, 1'b1, 1'b1, $urandom_range(150, 489), $urandom_range(0, 479));
    applyStimulus(4'h0, key, 1'b1, 1'b1, 1'b0, 0, 0);
  endtask

  task automatic doReset();
    #2;
    i_spawn   = '0;
    i_key     = '0;
    i_animate = 1'b0;
    i_pix_stb = 1'b0;
    i_active  = 1'b0;
    i_rst     = 1'b1;
    #1;
    checkOutput("reset_async", {o_r, o_g, o_b, o_hit, o_miss, o_overflow}, 32'h0);
    clearModel();
    repeat (2) @(posedge i_clk);
    #1;
    i_rst = 1'b0;
  endtask

  initial begin
    logic [3:0] keyState;
    logic [3:0] spawnBits;
    clearModel();
    #1;
    i_rst = 1'b1;
    repeat (3) @(posedge i_clk);
    #1;
    checkOutput("reset_outputs", {o_r, o_g, o_b, o_hit, o_miss, o_overflow}, 32'h0);
    i_rst = 1'b0;

    $display("[TB] spawn lanes 0/1 and draw lane 0 at the top");
    applyStimulus(4'b0011, 4'h0, 1'b0, 1'b0, 1'b0, 0, 0);
    applyStimulus(4'h0, 4'h0, 1'b1, 1'b1, 1'b0, 0, 0);
    applyStimulus(4'h0, 4'h0, 1'b0, 1'b1, 1'b1, 170, 0);
    checkOutput("req046_green", o_g, 32'hF);
    checkOutput("req046_red", o_r, 32'h0);
    applyStimulus(4'h0, 4'h0, 1'b0, 1'b1, 1'b1, 250, 5);
    checkOutput("lane1_red", {o_r, o_g, o_b}, 32'hF00);
    applyStimulus(4'h0, 4'h0, 1'b0, 1'b1, 1'b0, 170, 0);
    checkOutput("req046_inactive", {o_r, o_g, o_b}, 32'h0);

    $display("[TB] fall 200 ticks and hit lane 0");
    for (int i = 0; i < 200; i++) runFrame(4'h0, 4'h0);
    applyStimulus(4'h0, 4'b0001, 1'b0, 1'b0, 1'b0, 0, 0);
    checkOutput("req041_hit", o_hit[0], 32'h1);
    applyStimulus(4'h0, 4'b0001, 1'b0, 1'b0, 1'b0, 0, 0);
    checkOutput("held_key_no_hit", o_hit[0], 32'h0);
    applyStimulus(4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 0, 0);
    applyStimulus(4'h0, 4'b0001, 1'b0, 1'b0, 1'b0, 0, 0);
    checkOutput("req028_no_match", o_hit[0], 32'h0);
    applyStimulus(4'h0, 4'h0, 1'b0, 1'b1, 1'b1, 170, 405);
    checkOutput("req041_freed", {o_r, o_g, o_b}, 32'h0);

    $display("[TB] lane 1 falls to a miss");
    for (int i = 0; i < 8; i++) runFrame(4'h0, 4'h0);
    checkOutput("req042_early", o_miss[1], 32'h0);
    runFrame(4'h0, 4'h0);
    checkOutput("req042_miss", o_miss[1], 32'h1);

    $display("[TB] lane 2 overflow and lane 3 coincident hit");
    for (int i = 0; i < 5; i++) begin
      runFrame((i == 0) ? 4'b1100 : 4'b0100, 4'h0);
      checkOutput("req043_overflow", o_overflow[2], (i == 4) ? 32'h1 : 32'h0);
    end
    for (int i = 0; i < 204; i++) runFrame(4'h0, 4'h0);
    applyStimulus(4'h0, 4'b1000, 1'b1, 1'b1, 1'b0, 0, 0);
    checkOutput("req044_hit", o_hit[3], 32'h1);
    checkOutput("req044_no_miss", o_miss[3], 32'h0);
    applyStimulus(4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 0, 0);

    $display("[TB] reset with live notes");
    runFrame(4'b0111, 4'h0);
    for (int i = 0; i < 3; i++) runFrame(4'h0, 4'h0);
    applyStimulus(4'h0, 4'h0, 1'b0, 1'b1, 1'b1, 170, 8);
    checkOutput("req045_pre_green", o_g, 32'hF);
    doReset();
    runFrame(4'h0, 4'h0);
    applyStimulus(4'h0, 4'h0, 1'b0, 1'b1, 1'b1, 170, 8);
    checkOutput("req045_colour", {o_r, o_g, o_b}, 32'h0);
    for (int i = 0; i < 215; i++) runFrame(4'h0, (i % 2 == 1) ? 4'hF : 4'h0);

    $display("[TB] randomized traffic");
    keyState = '0;
    for (int i = 0; i < 1500; i++) begin
      spawnBits = '0;
      for (int l = 0; l < 4; l++) begin
        if ($urandom_range(0, 39) == 0) spawnBits[l] = 1'b1;
        if ($urandom_range(0, 5) == 0) keyState[l] = ~keyState[l];
      end
      applyStimulus(spawnBits, keyState, ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) != 0),
                    ($urandom_range(0, 4) != 0), $urandom_range(150, 489), $urandom_range(0, 479));
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/note_dropper.md
NOTE_DROPPER -- requirements
Module: note_dropper

Interface
REQ-001 SHALL have parameter LANE_X0, 160: left x of lane 0.
REQ-002 SHALL have parameter LANE_W, 80: lane width in px; 4 lanes, contiguous.
REQ-003 SHALL have parameter NOTE_H, 20: note height in px.
REQ-004 SHALL have parameter SPEED, 2: px moved per animate tick.
REQ-005 SHALL have parameter HIT_Y, 420: hit-line row.
REQ-006 SHALL have parameter HIT_WIN, 16: hit tolerance in px.
REQ-007 SHALL have port i_clk, input, 1: sole clock.
REQ-008 SHALL have port i_rst, input, 1: asynchronous, active-high reset.
REQ-009 SHALL have port i_pix_stb, input, 1: pixel strobe.
REQ-010 SHALL have port i_animate, input, 1: end-of-active-frame flag, level.
REQ-011 SHALL have port i_active, input, 1: active drawing region.
REQ-012 SHALL have port i_x, input, 10: current pixel x.
REQ-013 SHALL have port i_y, input, 9: current pixel y.
REQ-014 SHALL have port i_spawn, input, 4: per-lane spawn request, 1-cycle pulse.
REQ-015 SHALL have port i_key, input, 4: per-lane player key, level.
REQ-016 SHALL have port o_r/o_g/o_b, output, 4 each: pixel colour.
REQ-017 SHALL have ports o_hit and o_miss, output, 4 each: per-lane 1-cycle result pulses.
REQ-018 SHALL have port o_overflow, output, 4: per-lane 1-cycle spawn-rejected pulse.

Function
REQ-019 SHALL hold 4 slots per lane; each slot is a valid bit plus a 10-bit top-edge y.
REQ-020 SHALL define tick = i_animate & i_pix_stb, asserted once per frame.
REQ-021 SHALL latch each i_spawn bit into a per-lane pending flag, held until the next tick.
REQ-022 On tick with pending set, SHALL load the lowest-index slot that was free at cycle start with y=0, then clear pending.
REQ-023 If no slot is free on such a tick, SHALL pulse the lane's o_overflow for exactly that cycle.
REQ-024 On tick, every valid slot SHALL advance y by SPEED.
REQ-025 On tick, if the new bottom edge (y+NOTE_H) exceeds HIT_Y+HIT_WIN, the slot SHALL be invalidated and o_miss pulsed.
REQ-026 SHALL detect key rising edges against a registered copy of i_key.
REQ-027 On a rising edge, SHALL clear the lowest-index valid slot whose bottom edge lies in [HIT_Y-HIT_WIN, HIT_Y+HIT_WIN] (inclusive) and pulse o_hit.
REQ-028 A rising edge with no matching slot SHALL produce no pulse.
REQ-029 When a key edge and a tick coincide, SHALL evaluate the hit on the pre-move y; a hit slot is not moved, and no miss is reported for it.
REQ-030 A slot freed in a cycle SHALL NOT be reallocated in the same cycle.
REQ-031 SHALL perform all y arithmetic at 11 bits internally with no wrap; notes retire before y reaches 480.
REQ-032 SHALL register colour only on i_pix_stb cycles, giving one pixel strobe of latency; output is 0 when i_active is low.
REQ-033 A note SHALL be drawn when i_x lies inside its lane inset by 4 px each side and note_y <= i_y < note_y+NOTE_H.
REQ-034 Note colours SHALL be: lane0 green F, lane1 red F, lane2 red+green F, lane3 blue F.
REQ-035 Where notes overlap, the lower lane index SHALL win.

Reset
REQ-036 i_rst SHALL clear all valid bits, pending flags and the key register, and drive o_r/o_g/o_b/o_hit/o_miss/o_overflow to 0.
REQ-037 Reset asserted mid-frame SHALL take effect immediately; the first tick after release SHALL operate on the empty state.

Configuration
REQ-038 Macro NOTE_DROPPER_HITLINE_EN SHALL control the hit line.
REQ-039 With NOTE_DROPPER_HITLINE_EN defined, row i_y==HIT_Y across all 4 lanes SHALL be drawn white (F,F,F), overriding notes.
REQ-040 With NOTE_DROPPER_HITLINE_EN undefined, no line SHALL be drawn and all other behaviour SHALL be identical.

Verification
REQ-041 Spawn lane0, 200 ticks -> bottom reaches 420 at tick 200; o_hit[0] on key0 edge then; slot freed.
REQ-042 Spawn lane1, no key -> o_miss[1] pulses on the tick where the bottom first exceeds 436, i.e. tick 209.
REQ-043 Five spawns on lane2 across five frames with no keys -> o_overflow[2] pulses on the 5th tick only.
REQ-044 Key3 edge on the same cycle as a tick, with bottom=436 -> o_hit[3] pulses, no o_miss[3].
REQ-045 Reset asserted with 3 live notes -> outputs 0 at once; no hit/miss pulses after release; colour 0 next frame.
REQ-046 Pixel x=170,y=0, note at lane0 y=0 -> o_g=F one strobe later; i_active=0 -> 0.
